// File: rtl/rob_commit_pkg.sv
// Shared types and widths for the in-order commit buffer.
package rob_commit_pkg;

   localparam int ROB_ENTRIES_DEF = 8;
   localparam int ROB_ID_W_DEF    = $clog2(ROB_ENTRIES_DEF);
   localparam int PC_WIDTH        = 32;
   localparam int REG_ADDR_W      = 5;
   localparam int REG_DATA_W      = 32;

   typedef logic [ROB_ID_W_DEF-1:0] rob_id_t;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  xcpt;
      logic                  has_dest;
      logic [PC_WIDTH-1:0]   pc;
      logic [REG_ADDR_W-1:0] dest;
      logic [REG_DATA_W-1:0] data;
   } rob_entry_t;

endpackage

// File: rtl/rob_commit_ptr_ctrl.sv
// Head/tail/count bookkeeping for the commit buffer. Pointers wrap naturally
// because the entry count is a power of two; count tells full from empty.
module rob_commit_ptr_ctrl #(
   parameter int ROB_ENTRIES = 8,
   parameter int ROB_ID_W    = $clog2(ROB_ENTRIES)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                alloc,
   input  logic                commit,
   input  logic                flush,
   output logic [ROB_ID_W-1:0] head,
   output logic [ROB_ID_W-1:0] tail,
   output logic                full,
   output logic                empty
);

   logic [ROB_ID_W:0] count;

   // Pointer and occupancy update; a flush behaves like a reset.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (commit) head <= head + 1'b1;
         if (alloc)  tail <= tail + 1'b1;
         case ({alloc, commit})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == (ROB_ID_W+1)'(ROB_ENTRIES));
   assign empty = (count == '0);

endmodule

// File: rtl/rob_commit.sv
// In-order commit buffer: allocates in program order, accepts out-of-order
// completions from two pipes, and retires one entry per cycle from the head
// into the register-file write port or the exception/flush path.
module rob_commit
   import rob_commit_pkg::*;
#(
   parameter int ROB_ENTRIES = ROB_ENTRIES_DEF,
   parameter int ROB_ID_W    = $clog2(ROB_ENTRIES)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  alloc_valid,
   input  logic [PC_WIDTH-1:0]   alloc_pc,
   input  logic [REG_ADDR_W-1:0] alloc_dest,
   input  logic                  alloc_has_dest,
   output logic                  alloc_ready,
   output logic [ROB_ID_W-1:0]   alloc_id,
   input  logic                  cmpl0_valid,
   input  logic [ROB_ID_W-1:0]   cmpl0_id,
   input  logic [REG_DATA_W-1:0] cmpl0_data,
   input  logic                  cmpl0_xcpt,
   input  logic                  cmpl1_valid,
   input  logic [ROB_ID_W-1:0]   cmpl1_id,
   input  logic [REG_DATA_W-1:0] cmpl1_data,
   input  logic                  cmpl1_xcpt,
   output logic                  writeEn,
   output logic [REG_ADDR_W-1:0] dest_addr,
   output logic [REG_DATA_W-1:0] writeVal,
   output logic                  xcpt_valid,
   output logic [PC_WIDTH-1:0]   rmPC,
   output logic [REG_ADDR_W-1:0] rmAddr,
   output logic                  flush,
   output logic                  rob_empty
);

   rob_entry_t          rob [ROB_ENTRIES];
   rob_entry_t          head_e;
   logic [ROB_ID_W-1:0] head;
   logic [ROB_ID_W-1:0] tail;
   logic                full;
   logic                commit_fire;
   logic                commit_ok;
   logic                commit_xcpt;
   logic                alloc_fire;

   assign head_e      = rob[head];
   assign commit_fire = head_e.valid && head_e.done;
   assign commit_xcpt = commit_fire && head_e.xcpt;
   assign commit_ok   = commit_fire && !head_e.xcpt;

   // A slot freed by this cycle's commit is not reusable until next cycle.
   assign alloc_ready = !full && !commit_xcpt;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign alloc_id    = tail;

   rob_commit_ptr_ctrl #(
      .ROB_ENTRIES (ROB_ENTRIES),
      .ROB_ID_W    (ROB_ID_W)
   ) u_ptr (
      .clock  (clock),
      .reset  (reset),
      .alloc  (alloc_fire),
      .commit (commit_ok),
      .flush  (commit_xcpt),
      .head   (head),
      .tail   (tail),
      .full   (full),
      .empty  (rob_empty)
   );

   // Entry storage: retire, completions (port 0 written last so it wins), allocate.
   always_ff @(posedge clock) begin
      if (reset || commit_xcpt) begin
         for (int i = 0; i < ROB_ENTRIES; i++) rob[i] <= '0;
      end else begin
         if (commit_ok) rob[head].valid <= 1'b0;
         if (cmpl1_valid && rob[cmpl1_id].valid && !rob[cmpl1_id].done) begin
            rob[cmpl1_id].done <= 1'b1;
            rob[cmpl1_id].data <= cmpl1_data;
            rob[cmpl1_id].xcpt <= cmpl1_xcpt;
         end
         if (cmpl0_valid && rob[cmpl0_id].valid && !rob[cmpl0_id].done) begin
            rob[cmpl0_id].done <= 1'b1;
            rob[cmpl0_id].data <= cmpl0_data;
            rob[cmpl0_id].xcpt <= cmpl0_xcpt;
         end
         if (alloc_fire) begin
            rob[tail] <= '{valid: 1'b1, done: 1'b0, xcpt: 1'b0,
                           has_dest: alloc_has_dest, pc: alloc_pc,
                           dest: alloc_dest, data: '0};
         end
      end
   end

   // Registered commit port: strobes pulse for one cycle, payloads hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         writeEn    <= 1'b0;
         dest_addr  <= '0;
         writeVal   <= '0;
         xcpt_valid <= 1'b0;
         rmPC       <= '0;
         rmAddr     <= '0;
         flush      <= 1'b0;
      end else begin
         writeEn    <= 1'b0;
         xcpt_valid <= 1'b0;
         flush      <= 1'b0;
         if (commit_ok) begin
            writeEn   <= head_e.has_dest;
            dest_addr <= head_e.dest;
            writeVal  <= head_e.data;
         end
         if (commit_xcpt) begin
            xcpt_valid <= 1'b1;
            flush      <= 1'b1;
            rmPC       <= head_e.pc;
            rmAddr     <= head_e.dest;
         end
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a program-order queue model.
module tb_rob_commit;
   import rob_commit_pkg::*;

   localparam int N   = 8;
   localparam int IDW = 3;

   logic                  clock;
   logic                  reset;
   logic                  alloc_valid;
   logic [PC_WIDTH-1:0]   alloc_pc;
   logic [REG_ADDR_W-1:0] alloc_dest;
   logic                  alloc_has_dest;
   logic                  alloc_ready;
   logic [IDW-1:0]        alloc_id;
   logic                  cmpl0_valid, cmpl1_valid;
   logic [IDW-1:0]        cmpl0_id, cmpl1_id;
   logic [REG_DATA_W-1:0] cmpl0_data, cmpl1_data;
   logic                  cmpl0_xcpt, cmpl1_xcpt;
   logic                  writeEn;
   logic [REG_ADDR_W-1:0] dest_addr;
   logic [REG_DATA_W-1:0] writeVal;
   logic                  xcpt_valid;
   logic [PC_WIDTH-1:0]   rmPC;
   logic [REG_ADDR_W-1:0] rmAddr;
   logic                  flush;
   logic                  rob_empty;

   rob_commit #(.ROB_ENTRIES(N)) dut (
      .clock(clock), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_dest(alloc_dest),
      .alloc_has_dest(alloc_has_dest), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
      .cmpl0_valid(cmpl0_valid), .cmpl0_id(cmpl0_id), .cmpl0_data(cmpl0_data), .cmpl0_xcpt(cmpl0_xcpt),
      .cmpl1_valid(cmpl1_valid), .cmpl1_id(cmpl1_id), .cmpl1_data(cmpl1_data), .cmpl1_xcpt(cmpl1_xcpt),
      .writeEn(writeEn), .dest_addr(dest_addr), .writeVal(writeVal),
      .xcpt_valid(xcpt_valid), .rmPC(rmPC), .rmAddr(rmAddr),
      .flush(flush), .rob_empty(rob_empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: instructions in program order ----------------
   typedef struct {
      int                    id;
      logic [PC_WIDTH-1:0]   pc;
      logic [REG_ADDR_W-1:0] dest;
      bit                    has_dest;
      bit                    done;
      bit                    xcpt;
      logic [REG_DATA_W-1:0] data;
   } ment_t;

   ment_t q[$];
   int    seq = 0;
   bit    model_ok = 0;
   bit    m_rdy, m_xc;
   logic                  e_we, e_xv, e_fl;
   logic [REG_ADDR_W-1:0] e_dest, e_rm;
   logic [REG_DATA_W-1:0] e_val;
   logic [PC_WIDTH-1:0]   e_pc;

   task automatic complete(input logic [IDW-1:0] id, input logic [REG_DATA_W-1:0] d, input logic x);
      foreach (q[k]) begin
         if (q[k].id == int'(id) && !q[k].done) begin
            q[k].done = 1;
            q[k].data = d;
            q[k].xcpt = x;
         end
      end
   endtask

   // Compare DUT against the model, then advance the model by the upcoming edge.
   always @(negedge clock) begin
      if (model_ok) begin
         chk("writeEn",     64'(writeEn),    64'(e_we));
         chk("dest_addr",   64'(dest_addr),  64'(e_dest));
         chk("writeVal",    64'(writeVal),   64'(e_val));
         chk("xcpt_valid",  64'(xcpt_valid), 64'(e_xv));
         chk("rmPC",        64'(rmPC),       64'(e_pc));
         chk("rmAddr",      64'(rmAddr),     64'(e_rm));
         chk("flush",       64'(flush),      64'(e_fl));
         chk("alloc_ready", 64'(alloc_ready),
             64'((q.size() < N) && !(q.size() > 0 && q[0].done && q[0].xcpt)));
         chk("alloc_id",    64'(alloc_id),   64'(seq % N));
         chk("rob_empty",   64'(rob_empty),  64'(q.size() == 0));
      end
      if (reset) begin
         q.delete();
         seq = 0;
         e_we = 0; e_xv = 0; e_fl = 0; e_dest = '0; e_val = '0; e_pc = '0; e_rm = '0;
         model_ok = 1;
      end else if (model_ok) begin
         m_rdy = (q.size() < N) && !(q.size() > 0 && q[0].done && q[0].xcpt);
         m_xc  = 0;
         e_we = 0; e_xv = 0; e_fl = 0;
         if (q.size() > 0 && q[0].done) begin
            if (q[0].xcpt) begin
               e_xv = 1; e_fl = 1; e_pc = q[0].pc; e_rm = q[0].dest;
               q.delete();
               seq  = 0;
               m_xc = 1;
            end else begin
               e_we = q[0].has_dest; e_dest = q[0].dest; e_val = q[0].data;
               void'(q.pop_front());
            end
         end
         if (!m_xc) begin
            if (cmpl0_valid) complete(cmpl0_id, cmpl0_data, cmpl0_xcpt);
            if (cmpl1_valid) complete(cmpl1_id, cmpl1_data, cmpl1_xcpt);
            if (alloc_valid && m_rdy) begin
               q.push_back('{id: seq % N, pc: alloc_pc, dest: alloc_dest,
                             has_dest: alloc_has_dest, done: 0, xcpt: 0, data: '0});
               seq++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 0; cmpl0_valid = 0; cmpl1_valid = 0; cmpl0_xcpt = 0; cmpl1_xcpt = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      cyc(); cyc();
      reset = 0;
   endtask

   task automatic alloc_set(input logic [PC_WIDTH-1:0] pc, input logic [REG_ADDR_W-1:0] d, input logic hd);
      alloc_valid = 1; alloc_pc = pc; alloc_dest = d; alloc_has_dest = hd;
   endtask

   task automatic c0(input int id, input logic [REG_DATA_W-1:0] d, input logic x);
      cmpl0_valid = 1; cmpl0_id = IDW'(id); cmpl0_data = d; cmpl0_xcpt = x;
   endtask

   task automatic c1(input int id, input logic [REG_DATA_W-1:0] d, input logic x);
      cmpl1_valid = 1; cmpl1_id = IDW'(id); cmpl1_data = d; cmpl1_xcpt = x;
   endtask

   function automatic logic [IDW-1:0] pick_id();
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
         return IDW'(q[$urandom_range(0, q.size() - 1)].id);
      return IDW'($urandom_range(0, N - 1));
   endfunction

   initial begin
      reset = 1; alloc_pc = '0; alloc_dest = '0; alloc_has_dest = 0;
      cmpl0_id = '0; cmpl0_data = '0; cmpl1_id = '0; cmpl1_data = '0;
      idle();
      cyc(); cyc();
      reset = 0;
      chk("reset_empty", 64'(rob_empty), 64'd1);
      chk("reset_ready", 64'(alloc_ready), 64'd1);
      chk("reset_we", 64'(writeEn), 64'd0);

      // Out-of-order completion, in-order retire on three consecutive cycles.
      alloc_set(32'h1000, 5'd1, 1); cyc();
      alloc_set(32'h1004, 5'd2, 1); cyc();
      alloc_set(32'h1008, 5'd3, 1); cyc();
      alloc_valid = 0;
      c0(2, 32'h30, 0); cyc();
      c0(0, 32'h10, 0); cyc();
      c0(1, 32'h20, 0); cyc();
      chk("ooo_c1", 64'({writeEn, dest_addr, writeVal}), 64'({1'b1, 5'd1, 32'h10}));
      idle(); cyc();
      chk("ooo_c2", 64'({writeEn, dest_addr, writeVal}), 64'({1'b1, 5'd2, 32'h20}));
      cyc();
      chk("ooo_c3", 64'({writeEn, dest_addr, writeVal}), 64'({1'b1, 5'd3, 32'h30}));
      cyc();
      chk("ooo_idle", 64'({writeEn, rob_empty}), 64'({1'b0, 1'b1}));

      // Fill, then commit while full: same-cycle alloc refused, then wrap.
      do_reset();
      for (int i = 0; i < N; i++) begin
         chk("fill_id", 64'(alloc_id), 64'(i));
         alloc_set(32'h2000 + 32'(4 * i), 5'(8 + i), 1);
         cyc();
      end
      alloc_valid = 0;
      chk("full_ready", 64'(alloc_ready), 64'd0);
      c0(0, 32'h77, 0); cyc();
      idle();
      alloc_set(32'h2100, 5'd20, 1);
      chk("full_commit_ready", 64'(alloc_ready), 64'd0);
      cyc();
      alloc_valid = 0;
      chk("full_commit_we", 64'({writeEn, writeVal}), 64'({1'b1, 32'h77}));
      chk("wrap_ready", 64'(alloc_ready), 64'd1);
      chk("wrap_id", 64'(alloc_id), 64'd0);
      for (int k = 1; k < N; k += 2) begin
         c0(k, 32'(k), 0);
         if (k + 1 < N) c1(k + 1, 32'(k + 100), 0);
         cyc();
         idle();
      end
      repeat (10) cyc();
      chk("drain_empty", 64'(rob_empty), 64'd1);

      // Exception behind a clean entry.
      do_reset();
      alloc_set(32'h1000, 5'd4, 1); cyc();
      alloc_set(32'h1004, 5'd5, 1); cyc();
      alloc_set(32'h1008, 5'd6, 1); cyc();
      alloc_valid = 0;
      c0(0, 32'h44, 0); c1(1, 32'hDEAD, 1); cyc();
      idle(); cyc();
      chk("xc_pre_we", 64'({writeEn, dest_addr, writeVal}), 64'({1'b1, 5'd4, 32'h44}));
      chk("xc_ready", 64'(alloc_ready), 64'd0);
      alloc_set(32'h3000, 5'd9, 1);
      cyc();
      alloc_valid = 0;
      chk("xc_pulse", 64'({xcpt_valid, flush, writeEn}), 64'({1'b1, 1'b1, 1'b0}));
      chk("xc_pc", 64'(rmPC), 64'h1004);
      chk("xc_addr", 64'(rmAddr), 64'd5);
      chk("xc_empty", 64'({rob_empty, alloc_id}), 64'({1'b1, 3'd0}));
      cyc();
      chk("xc_clear", 64'({xcpt_valid, flush}), 64'd0);

      // Both pipes target the same id: port 0 wins.
      do_reset();
      alloc_set(32'h10, 5'd7, 1); cyc();
      alloc_set(32'h14, 5'd8, 1); cyc();
      alloc_set(32'h18, 5'd9, 1); cyc();
      alloc_valid = 0;
      c0(0, 32'h1, 0); c1(1, 32'h2, 0); cyc();
      c0(2, 32'hAA, 0); c1(2, 32'hBB, 0); cyc();
      idle(); cyc(); cyc();
      chk("dual_val", 64'({writeEn, dest_addr, writeVal}), 64'({1'b1, 5'd9, 32'hAA}));

      // No destination register: no write, head still advances.
      do_reset();
      alloc_set(32'h3000, 5'd7, 0); cyc();
      alloc_valid = 0;
      c0(0, 32'h55, 0); cyc();
      idle(); cyc();
      chk("nodest_we", 64'(writeEn), 64'd0);
      chk("nodest_adv", 64'({rob_empty, alloc_id}), 64'({1'b1, 3'd1}));

      // Reset mid-operation with pending work; stale completions ignored after.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alloc_set(32'h4000 + 32'(4 * i), 5'(10 + i), 1);
         cyc();
      end
      alloc_valid = 0;
      c0(0, 32'h99, 0); cyc();
      c0(1, 32'h98, 0); cyc();
      reset = 1;
      alloc_set(32'h5000, 5'd1, 1);
      c0(2, 32'h97, 0); c1(3, 32'h96, 0);
      cyc();
      chk("rst_out", 64'({writeEn, xcpt_valid, flush, dest_addr, rmAddr}), 64'd0);
      chk("rst_val", 64'({writeVal, rmPC}), 64'd0);
      chk("rst_empty", 64'(rob_empty), 64'd1);
      reset = 0;
      idle();
      c0(0, 32'h1, 0); c1(1, 32'h2, 0); cyc();
      idle();
      alloc_set(32'h6000, 5'd2, 1); cyc();
      alloc_valid = 0;
      repeat (3) cyc();
      chk("stale_we", 64'({writeEn, rob_empty}), 64'({1'b0, 1'b0}));
      c0(0, 32'h61, 0); cyc();
      idle(); repeat (2) cyc();

      // Randomized traffic, checked every cycle by the model.
      for (int n = 0; n < 3000; n++) begin
         reset          = ($urandom_range(0, 299) == 0);
         alloc_valid    = ($urandom_range(0, 9) < 6);
         alloc_pc       = $urandom;
         alloc_dest     = REG_ADDR_W'($urandom_range(0, 31));
         alloc_has_dest = ($urandom_range(0, 4) != 0);
         cmpl0_valid    = ($urandom_range(0, 19) < 7);
         cmpl0_id       = pick_id();
         cmpl0_data     = $urandom;
         cmpl0_xcpt     = ($urandom_range(0, 39) == 0);
         cmpl1_valid    = ($urandom_range(0, 19) < 7);
         cmpl1_id       = pick_id();
         cmpl1_data     = $urandom;
         cmpl1_xcpt     = ($urandom_range(0, 39) == 0);
         cyc();
      end
      reset = 0;
      idle();
      repeat (3) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
